// File: rtl/kr580_pic.sv
// kr580_pic: vectored priority interrupt controller for a KR580 CPU; define KR580_PIC_AUTO_EOI_EN for automatic end-of-interrupt
module kr580_pic #(
  parameter int CHANNELS = 8,
  parameter logic [7:0] BASE_PORT = 8'hF0
) (
  input  logic                pin_clk,
  input  logic                pin_rst,
  input  logic [CHANNELS-1:0] pin_irq,
  input  logic [7:0]          pin_pa,
  input  logic [7:0]          pin_po,
  input  logic                pin_pw,
  output logic [7:0]          pin_pi,
  output logic                pin_sel,
  input  logic                pin_iack,
  output logic                pin_intr,
  output logic [7:0]          pin_vect
);
  localparam logic [7:0] P0 = BASE_PORT;
  localparam logic [7:0] P1 = BASE_PORT + 8'd1;
  localparam logic [7:0] P2 = BASE_PORT + 8'd2;
  localparam logic [CHANNELS-1:0] ONE = CHANNELS'(1);
  logic [CHANNELS-1:0] sync1_q, sync2_q, prev_q, irr_q, isr_q, imr_q;
  logic [CHANNELS-1:0] irr_d, isr_d, imr_d;
  logic [CHANNELS-1:0] edge_w, low_w, prio_w, elig_w, pick_w;
  logic [1:0] live_q;
  logic intr_q, intr_d;
  logic [7:0] vect_q, vect_d;
  logic [2:0] ch;
  logic wr_imr, wr_eoi;
  assign wr_imr = pin_pw && pin_pa == P0;
  assign wr_eoi = pin_pw && pin_pa == P1;
  // prev_q starts at ones, so an edge needs a genuine post-reset 0 sample first
  assign edge_w = sync2_q & ~prev_q;
  // lowest in-service bit; only channels strictly below it may interrupt (all when ISR=0)
  assign low_w  = isr_q & (~isr_q + ONE);
  assign prio_w = low_w - ONE;
  assign elig_w = irr_q & ~imr_q & prio_w;
  assign pick_w = elig_w & (~elig_w + ONE);
  assign pin_sel  = pin_pa == P0 || pin_pa == P1 || pin_pa == P2;
  assign pin_pi   = pin_pa == P0 ? 8'(imr_q) : pin_pa == P1 ? 8'(irr_q) : pin_pa == P2 ? 8'(isr_q) : 8'h00;
  assign pin_intr = intr_q;
  assign pin_vect = vect_q;
  // index of the lowest-numbered eligible channel
  always_comb begin
    ch = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) if (elig_w[i]) ch = 3'(i);
  end
  // next state: acknowledge, mask write, EOI and newly synchronized edges (edge wins over ack clear)
  always_comb begin
    irr_d  = (irr_q & ~(pin_iack ? pick_w : '0)) | edge_w;
    imr_d  = wr_imr ? pin_po[CHANNELS-1:0] : imr_q;
`ifdef KR580_PIC_AUTO_EOI_EN
    isr_d  = '0;
`else
    isr_d  = (isr_q & ~(wr_eoi ? low_w : '0)) | (pin_iack ? pick_w : '0);
`endif
    intr_d = |elig_w;
    vect_d = pin_iack ? (|elig_w ? {2'b11, ch, 3'b111} : 8'hFF) : vect_q;
  end
  // state registers with synchronous reset
  always_ff @(posedge pin_clk) begin
    if (pin_rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '1;
      live_q  <= '0;
      irr_q   <= '0;
      isr_q   <= '0;
      imr_q   <= '1;
      intr_q  <= 1'b0;
      vect_q  <= 8'hFF;
    end else begin
      sync1_q <= pin_irq;
      sync2_q <= sync1_q;
      live_q  <= {live_q[0], 1'b1};
      prev_q  <= live_q[1] ? sync2_q : '1;
      irr_q   <= irr_d;
      isr_q   <= isr_d;
      imr_q   <= imr_d;
      intr_q  <= intr_d;
      vect_q  <= vect_d;
    end
  end
endmodule

// File: tb/tb_kr580_pic.sv
// tb_kr580_pic: directed and random stimulus against a behavioural interrupt-controller model
module tb_kr580_pic;
  logic pin_clk, pin_rst, pin_pw, pin_iack, pin_sel, pin_intr;
  logic [7:0] pin_irq, pin_pa, pin_po, pin_pi, pin_vect;
  int total = 0;
  int bad = 0;
  logic [7:0] m_irr, m_isr, m_imr, m_vect;
  logic m_intr;
  logic [7:0] smp[$];

  kr580_pic dut (
    .pin_clk(pin_clk), .pin_rst(pin_rst), .pin_irq(pin_irq), .pin_pa(pin_pa),
    .pin_po(pin_po), .pin_pw(pin_pw), .pin_pi(pin_pi), .pin_sel(pin_sel),
    .pin_iack(pin_iack), .pin_intr(pin_intr), .pin_vect(pin_vect)
  );

  initial pin_clk = 1'b0;
  always #5 pin_clk = ~pin_clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // one clock edge of the reference: irq levels reach the edge detector two samples late
  task automatic model(input logic [7:0] irq, input logic ack, input logic w,
                       input logic [7:0] a, input logic [7:0] d, input logic r);
    logic [7:0] e;
    int lo, p;
    if (r) begin
      m_irr = 8'h00; m_isr = 8'h00; m_imr = 8'hFF; m_intr = 1'b0; m_vect = 8'hFF;
      smp.delete();
    end else begin
      e = smp.size() >= 3 ? (smp[1] & ~smp[2]) : 8'h00;
      lo = 8;
      for (int i = 7; i >= 0; i--) if (m_isr[i]) lo = i;
      p = -1;
      for (int i = 7; i >= 0; i--) if (m_irr[i] && !m_imr[i] && i < lo) p = i;
      m_intr = p >= 0;
      if (ack) begin
        m_vect = p >= 0 ? (8'hC7 | 8'(p * 8)) : 8'hFF;
        if (p >= 0) begin
          m_irr[p] = 1'b0;
`ifndef KR580_PIC_AUTO_EOI_EN
          m_isr[p] = 1'b1;
`endif
        end
      end
      if (w && a == 8'hF0) m_imr = d;
`ifndef KR580_PIC_AUTO_EOI_EN
      if (w && a == 8'hF1 && lo < 8) m_isr[lo] = 1'b0;
`endif
      m_irr = m_irr | e;
      smp.push_front(irq);
      if (smp.size() > 3) void'(smp.pop_back());
    end
  endtask

  task automatic peek();
    for (int j = 0; j < 3; j++) begin
      pin_pa = 8'hF0 + 8'(j);
      #1;
      chk(j == 0 ? "pi_imr" : j == 1 ? "pi_irr" : "pi_isr", pin_pi, j == 0 ? m_imr : j == 1 ? m_irr : m_isr);
      chk("sel_in", 8'(pin_sel), 8'h01);
    end
    pin_pa = 8'h37;
    #1;
    chk("pi_other", pin_pi, 8'h00);
    chk("sel_out", 8'(pin_sel), 8'h00);
  endtask

  task automatic step(input logic [7:0] i_v, input logic a_v = 1'b0, input logic w_v = 1'b0,
                      input logic [7:0] pa_v = 8'h00, input logic [7:0] po_v = 8'h00, input logic r_v = 1'b0);
    pin_irq = i_v; pin_iack = a_v; pin_pw = w_v; pin_pa = pa_v; pin_po = po_v; pin_rst = r_v;
    @(posedge pin_clk);
    model(i_v, a_v, w_v, pa_v, po_v, r_v);
    #1;
    chk("intr", 8'(pin_intr), 8'(m_intr));
    chk("vect", pin_vect, m_vect);
    pin_iack = 1'b0; pin_pw = 1'b0; pin_rst = 1'b0;
    peek();
  endtask

  task automatic rd(input logic [7:0] a, output logic [7:0] v);
    pin_pa = a;
    #1;
    v = pin_pi;
  endtask

  initial begin
    logic [7:0] v, cur, ad;
    pin_irq = 8'h00; pin_iack = 1'b0; pin_pw = 1'b0; pin_pa = 8'h00; pin_po = 8'h00; pin_rst = 1'b1;
    step(8'h00, 0, 0, 8'h00, 8'h00, 1);
    step(8'h00, 0, 0, 8'h00, 8'h00, 1);
    chk("rst_vect", pin_vect, 8'hFF);
    rd(8'hF0, v); chk("rst_imr", v, 8'hFF);
    repeat (4) step(8'h00);
    // single request on ch3
    step(8'h00, 0, 1, 8'hF0, 8'h00);
    step(8'h08); step(8'h08);
    step(8'h00); step(8'h00);
    chk("r30_intr", 8'(pin_intr), 8'h01);
    rd(8'hF1, v); chk("r30_irr", v, 8'h08);
    step(8'h00, 1);
    chk("r30_vect", pin_vect, 8'hDF);
    step(8'h00);
    chk("r30_intr_lo", 8'(pin_intr), 8'h00);
    rd(8'hF2, v);
`ifdef KR580_PIC_AUTO_EOI_EN
    chk("r30_isr", v, 8'h00);
`else
    chk("r30_isr", v, 8'h08);
`endif
    // nesting: ch5 blocked by ch3 in service, ch1 preempts
    step(8'h20); step(8'h20);
    repeat (4) step(8'h00);
`ifndef KR580_PIC_AUTO_EOI_EN
    chk("r31_blocked", 8'(pin_intr), 8'h00);
`endif
    step(8'h02); step(8'h02);
    repeat (4) step(8'h00);
    chk("r31_intr", 8'(pin_intr), 8'h01);
    step(8'h00, 1);
`ifndef KR580_PIC_AUTO_EOI_EN
    chk("r31_vect", pin_vect, 8'hCF);
`endif
    step(8'h00, 0, 1, 8'hF1);
    rd(8'hF2, v);
`ifdef KR580_PIC_AUTO_EOI_EN
    chk("r31_eoi", v, 8'h00);
`else
    chk("r31_eoi", v, 8'h08);
`endif
    // masked request latches, unmasking raises intr
    step(8'h00, 0, 1, 8'hF0, 8'hFF);
    step(8'h01); step(8'h01);
    repeat (4) step(8'h00);
    chk("r32_masked", 8'(pin_intr), 8'h00);
    rd(8'hF1, v); chk("r32_irr0", v & 8'h01, 8'h01);
    step(8'h00, 0, 1, 8'hF0, 8'hFE);
    step(8'h00);
    chk("r32_unmask", 8'(pin_intr), 8'h01);
    // spurious ack, then ack colliding with a fresh ch2 edge
    step(8'h00, 0, 0, 8'h00, 8'h00, 1);
    repeat (4) step(8'h00);
    step(8'h00, 1);
    chk("r33_spur", pin_vect, 8'hFF);
    rd(8'hF1, v); chk("r33_irr", v, 8'h00);
    step(8'h00, 0, 1, 8'hF0, 8'h00);
    step(8'h04); step(8'h00); step(8'h00);
    step(8'h04); step(8'h04);
    step(8'h04, 1);
    chk("r33_vect", pin_vect, 8'hD7);
    step(8'h00);
    rd(8'hF1, v); chk("r33_keep", v & 8'h04, 8'h04);
    // reset mid-operation with a request held high through it
    step(8'h10); step(8'h10);
    repeat (3) step(8'h00);
    step(8'h40, 0, 0, 8'h00, 8'h00, 1);
    step(8'h40, 0, 0, 8'h00, 8'h00, 1);
    rd(8'hF1, v); chk("r34_irr", v, 8'h00);
    rd(8'hF2, v); chk("r34_isr", v, 8'h00);
    rd(8'hF0, v); chk("r34_imr", v, 8'hFF);
    step(8'h40, 0, 1, 8'hF0, 8'h00);
    repeat (5) step(8'h40);
    rd(8'hF1, v); chk("r34_noedge", v, 8'h00);
    step(8'h00); step(8'h00);
    step(8'h10); step(8'h10);
    repeat (2) step(8'h00);
    step(8'h00, 1);
    chk("r34_vect", pin_vect, 8'hE7);
    rd(8'hF2, v);
`ifdef KR580_PIC_AUTO_EOI_EN
    chk("r34_isr_auto", v, 8'h00);
`else
    chk("r34_isr_auto", v, 8'h10);
`endif
    // random traffic
    cur = 8'h00;
    for (int k = 0; k < 500; k++) begin
      if ($urandom_range(0, 3) == 0) cur = cur ^ (8'h01 << $urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0: ad = 8'hF0;
        1: ad = 8'hF1;
        2: ad = 8'hF2;
        default: ad = 8'h33;
      endcase
      step(cur, $urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0, ad,
           8'($urandom & $urandom), $urandom_range(0, 120) == 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
